// File: rtl/ps2_defs_pkg.sv
// Shared definitions for the PS/2 line builder: scancode constants,
// the FSM state encoding and the ASCII fill character.
package ps2_defs_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] ASCII_NUL = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BREAK,
    S_EXT,
    S_EXT_BRK,
    S_COMMIT
  } state_t;

endpackage

// File: rtl/ps2_scancode_to_ascii.sv
// Combinational scancode-set-2 to ASCII decoder for letters, digits and space.
// Letters honour shift; digits and space do not.
module ps2_scancode_to_ascii (
  input  logic [7:0] scancode,
  input  logic       shift,
  output logic [7:0] ascii,
  output logic       is_printable
);

  logic [7:0] lc;
  logic       is_letter;

  always_comb begin
    lc           = 8'h00;
    is_letter    = 1'b1;
    ascii        = 8'h00;
    is_printable = 1'b1;
    case (scancode)
      8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
      8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
      8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
      8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
      8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
      8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
      8'h35: lc = "y";  8'h1A: lc = "z";
      default: is_letter = 1'b0;
    endcase

    if (is_letter) begin
      // Upper case sits exactly 0x20 below lower case in ASCII.
      ascii = shift ? (lc - 8'h20) : lc;
    end else begin
      case (scancode)
        8'h45: ascii = "0";  8'h16: ascii = "1";  8'h1E: ascii = "2";
        8'h26: ascii = "3";  8'h25: ascii = "4";  8'h2E: ascii = "5";
        8'h36: ascii = "6";  8'h3D: ascii = "7";  8'h3E: ascii = "8";
        8'h46: ascii = "9";  8'h29: ascii = " ";
        default: is_printable = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ps2_line_builder.sv
// Assembles decoded PS/2 keystrokes into a fixed-width command line, echoing it
// continuously and pulsing ready for one cycle when Enter commits the line.
module ps2_line_builder
  import ps2_defs_pkg::*;
#(
  parameter int LINE_CHARS = 32,
  parameter int CHAR_W     = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [7:0]                         ps2_key_data,
  input  logic                               ps2_key_pressed,
  output logic [LINE_CHARS*CHAR_W-1:0]       ps2_line_content,
  output logic                               ps2_line_ready,
  output logic [$clog2(LINE_CHARS+1)-1:0]    ps2_line_length,
  output logic                               ps2_line_overflow
);

  localparam int LEN_W = $clog2(LINE_CHARS + 1);
  localparam int IDX_W = $clog2(LINE_CHARS);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(LINE_CHARS);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  state_t            state_q, state_d;
  logic [CHAR_W-1:0] buf_q [LINE_CHARS];
  logic [CHAR_W-1:0] buf_d [LINE_CHARS];
  logic [LEN_W-1:0]  len_q, len_d;
  logic              ovf_q, ovf_d;
  logic              shift_q, shift_d;
  logic [7:0]        ascii;
  logic              is_printable;

  ps2_scancode_to_ascii u_decode (
    .scancode     (ps2_key_data),
    .shift        (shift_q),
    .ascii        (ascii),
    .is_printable (is_printable)
  );

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    shift_d = shift_q;

    // The commit cycle clears first so a same-cycle keystroke edits the fresh line.
    if (state_q == S_COMMIT) begin
      for (int i = 0; i < LINE_CHARS; i++) buf_d[i] = CHAR_W'(ASCII_NUL);
      len_d   = '0;
      ovf_d   = 1'b0;
      state_d = S_IDLE;
    end

    if (ps2_key_pressed) begin
      case (state_q)
        S_BREAK: begin
          state_d = S_IDLE;
          if (ps2_key_data == SC_LSHIFT || ps2_key_data == SC_RSHIFT) shift_d = 1'b0;
        end
        S_EXT:     state_d = (ps2_key_data == SC_BREAK) ? S_EXT_BRK : S_IDLE;
        S_EXT_BRK: state_d = S_IDLE;
        default: begin
          if (ps2_key_data == SC_BREAK) begin
            state_d = S_BREAK;
          end else if (ps2_key_data == SC_EXT) begin
            state_d = S_EXT;
          end else if (ps2_key_data == SC_LSHIFT || ps2_key_data == SC_RSHIFT) begin
            shift_d = 1'b1;
          end else if (ps2_key_data == SC_ENTER) begin
            state_d = S_COMMIT;
          end else if (ps2_key_data == SC_BKSP) begin
            if (len_d != '0) begin
              buf_d[IDX_W'(len_d - LEN_ONE)] = CHAR_W'(ASCII_NUL);
              len_d = len_d - LEN_ONE;
            end
          end else if (is_printable) begin
            if (len_d < FULL_LEN) begin
              buf_d[IDX_W'(len_d)] = CHAR_W'(ascii);
              len_d = len_d + LEN_ONE;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      buf_q   <= '{default: '0};
      len_q   <= '0;
      ovf_q   <= 1'b0;
      shift_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      shift_q <= shift_d;
    end
  end

  // Slot 0 is the leftmost character, so it occupies the top byte.
  always_comb begin
    ps2_line_content = '0;
    for (int i = 0; i < LINE_CHARS; i++)
      ps2_line_content[(LINE_CHARS-1-i)*CHAR_W +: CHAR_W] = buf_q[i];
  end

  assign ps2_line_ready    = (state_q == S_COMMIT);
  assign ps2_line_length   = len_q;
  assign ps2_line_overflow = ovf_q;

endmodule

// File: tb/tb_ps2_line_builder.sv
// Directed, table-driven bench for ps2_line_builder with a few hand-written
// multi-cycle sequences for overflow, reset and commit-cycle keystrokes.
module tb_ps2_line_builder;

  logic         clock = 1'b0;
  logic         reset;
  logic [7:0]   ps2_key_data;
  logic         ps2_key_pressed;
  logic [255:0] ps2_line_content;
  logic         ps2_line_ready;
  logic [5:0]   ps2_line_length;
  logic         ps2_line_overflow;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [7:0]   key;
    logic         pr;
    logic [255:0] content;
    logic [5:0]   len;
    logic         rdy;
    logic         ovf;
  } vec_t;

  vec_t vecs[$];

  ps2_line_builder dut (
    .clock             (clock),
    .reset             (reset),
    .ps2_key_data      (ps2_key_data),
    .ps2_key_pressed   (ps2_key_pressed),
    .ps2_line_content  (ps2_line_content),
    .ps2_line_ready    (ps2_line_ready),
    .ps2_line_length   (ps2_line_length),
    .ps2_line_overflow (ps2_line_overflow)
  );

  always #5 clock = ~clock;

  function automatic logic [255:0] ln(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    return {a, b, c, 232'h0};
  endfunction

  task automatic add(input logic [7:0] key, input logic pr, input logic [255:0] content,
                     input logic [5:0] len, input logic rdy, input logic ovf);
    vec_t v;
    v.key = key; v.pr = pr; v.content = content; v.len = len; v.rdy = rdy; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  task automatic step(input logic [7:0] key, input logic pr, input logic rst);
    @(negedge clock);
    ps2_key_data    = key;
    ps2_key_pressed = pr;
    reset           = rst;
    @(posedge clock);
    #1;
    ps2_key_pressed = 1'b0;
    reset           = 1'b0;
  endtask

  task automatic check(input string name, input logic [255:0] content, input logic [5:0] len,
                       input logic rdy, input logic ovf);
    n_total += 4;
    if (ps2_line_content === content) n_pass++;
    else $display("FAIL %s content got %h want %h", name, ps2_line_content, content);
    if (ps2_line_length === len) n_pass++;
    else $display("FAIL %s length got %0d want %0d", name, ps2_line_length, len);
    if (ps2_line_ready === rdy) n_pass++;
    else $display("FAIL %s ready got %b want %b", name, ps2_line_ready, rdy);
    if (ps2_line_overflow === ovf) n_pass++;
    else $display("FAIL %s overflow got %b want %b", name, ps2_line_overflow, ovf);
  endtask

  initial begin
    reset = 1'b1;
    ps2_key_data = 8'h00;
    ps2_key_pressed = 1'b0;

    // h i Enter, then the clear cycle
    add(8'h33, 1, ln(8'h68, 0, 0), 1, 0, 0);
    add(8'h43, 1, ln(8'h68, 8'h69, 0), 2, 0, 0);
    add(8'h5A, 1, ln(8'h68, 8'h69, 0), 2, 1, 0);
    add(8'h00, 0, '0, 0, 0, 0);
    // shift A, release shift, a
    add(8'h12, 1, '0, 0, 0, 0);
    add(8'h1C, 1, ln(8'h41, 0, 0), 1, 0, 0);
    add(8'hF0, 1, ln(8'h41, 0, 0), 1, 0, 0);
    add(8'h12, 1, ln(8'h41, 0, 0), 1, 0, 0);
    add(8'h1C, 1, ln(8'h41, 8'h61, 0), 2, 0, 0);
    add(8'h5A, 1, ln(8'h41, 8'h61, 0), 2, 1, 0);
    add(8'h00, 0, '0, 0, 0, 0);
    // backspace at empty, then type and erase
    add(8'h66, 1, '0, 0, 0, 0);
    add(8'h16, 1, ln(8'h31, 0, 0), 1, 0, 0);
    add(8'h66, 1, '0, 0, 0, 0);
    // extended make/break ignored, FSM back in idle afterwards
    add(8'h16, 1, ln(8'h31, 0, 0), 1, 0, 0);
    add(8'hE0, 1, ln(8'h31, 0, 0), 1, 0, 0);
    add(8'h75, 1, ln(8'h31, 0, 0), 1, 0, 0);
    add(8'hE0, 1, ln(8'h31, 0, 0), 1, 0, 0);
    add(8'hF0, 1, ln(8'h31, 0, 0), 1, 0, 0);
    add(8'h75, 1, ln(8'h31, 0, 0), 1, 0, 0);
    add(8'h29, 1, ln(8'h31, 8'h20, 0), 2, 0, 0);
    add(8'h05, 1, ln(8'h31, 8'h20, 0), 2, 0, 0);
    add(8'h5A, 1, ln(8'h31, 8'h20, 0), 2, 1, 0);
    add(8'h00, 0, '0, 0, 0, 0);
    // right shift: digit unaffected, letter upper, release, letter lower
    add(8'h59, 1, '0, 0, 0, 0);
    add(8'h45, 1, ln(8'h30, 0, 0), 1, 0, 0);
    add(8'h1A, 1, ln(8'h30, 8'h5A, 0), 2, 0, 0);
    add(8'hF0, 1, ln(8'h30, 8'h5A, 0), 2, 0, 0);
    add(8'h59, 1, ln(8'h30, 8'h5A, 0), 2, 0, 0);
    add(8'h1A, 1, ln(8'h30, 8'h5A, 8'h7A), 3, 0, 0);
    add(8'h5A, 1, ln(8'h30, 8'h5A, 8'h7A), 3, 1, 0);
    add(8'h00, 0, '0, 0, 0, 0);

    step(8'h00, 0, 1);
    step(8'h00, 0, 1);
    check("reset", '0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].key, vecs[i].pr, 0);
      check($sformatf("vec%0d", i), vecs[i].content, vecs[i].len, vecs[i].rdy, vecs[i].ovf);
    end

    // fill the line, then one more char overflows
    for (int i = 0; i < 32; i++) step(8'h1C, 1, 0);
    check("full", {32{8'h61}}, 6'd32, 0, 0);
    step(8'h1C, 1, 0);
    check("overflow", {32{8'h61}}, 6'd32, 0, 1);
    step(8'h5A, 1, 0);
    check("ovf_commit", {32{8'h61}}, 6'd32, 1, 1);
    step(8'h00, 0, 0);
    check("ovf_cleared", '0, 0, 0, 0);

    // reset mid-line wins over a simultaneous strobe, and clears shift
    step(8'h12, 1, 0);
    step(8'h1C, 1, 0);
    step(8'h32, 1, 0);
    step(8'h21, 1, 0);
    check("pre_reset", ln(8'h41, 8'h42, 8'h43), 3, 0, 0);
    step(8'h1C, 1, 1);
    check("mid_reset", '0, 0, 0, 0);
    step(8'h1C, 1, 0);
    check("shift_reset", ln(8'h61, 0, 0), 1, 0, 0);

    // keystroke in the ready cycle lands in slot 0 of the cleared line
    step(8'h33, 1, 0);
    step(8'h5A, 1, 0);
    check("commit2", ln(8'h61, 8'h68, 0), 2, 1, 0);
    step(8'h1C, 1, 0);
    check("commit_strobe", ln(8'h61, 0, 0), 1, 0, 0);
    step(8'h00, 0, 0);
    check("commit_hold", ln(8'h61, 0, 0), 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
